// File: rtl/ps2_keyboard.sv
// PS/2 scan-code set 2 receiver and Hack key-code translator feeding the kbIn word.
// Holds the code of the currently pressed mapped key, 0 when none is held.
module ps2_keyboard #(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] key,
    output logic        scan_valid,
    output logic [7:0]  scan_code,
    output logic        frame_err
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] clk_sync, data_sync;
    logic                   clk_prev;
    logic [2:0]             bit_cnt;
    logic [7:0]             shreg;
    logic                   par;
    logic [TW-1:0]          tcnt;
    logic                   ext, brk, shift;
    logic [7:0]             key_lo;
    logic                   fall_p0, bit_p0;
    logic [7:0]             code_p0;

    // Returns 0 for unmapped codes; shift only affects letters.
    function automatic logic [7:0] xlate(input logic e, input logic [7:0] b, input logic sh);
        logic [7:0] r;
        logic [4:0] li;
        logic       letter;
        r = 8'd0;
        li = 5'd0;
        letter = 1'b0;
        if (e) begin
            case (b)
                8'h6B: r = 8'd130;
                8'h75: r = 8'd131;
                8'h74: r = 8'd132;
                8'h72: r = 8'd133;
                8'h6C: r = 8'd134;
                8'h69: r = 8'd135;
                8'h7D: r = 8'd136;
                8'h7A: r = 8'd137;
                8'h70: r = 8'd138;
                8'h71: r = 8'd139;
                default: r = 8'd0;
            endcase
        end else begin
            case (b)
                8'h1C: begin letter = 1'b1; li = 5'd0;  end
                8'h32: begin letter = 1'b1; li = 5'd1;  end
                8'h21: begin letter = 1'b1; li = 5'd2;  end
                8'h23: begin letter = 1'b1; li = 5'd3;  end
                8'h24: begin letter = 1'b1; li = 5'd4;  end
                8'h2B: begin letter = 1'b1; li = 5'd5;  end
                8'h34: begin letter = 1'b1; li = 5'd6;  end
                8'h33: begin letter = 1'b1; li = 5'd7;  end
                8'h43: begin letter = 1'b1; li = 5'd8;  end
                8'h3B: begin letter = 1'b1; li = 5'd9;  end
                8'h42: begin letter = 1'b1; li = 5'd10; end
                8'h4B: begin letter = 1'b1; li = 5'd11; end
                8'h3A: begin letter = 1'b1; li = 5'd12; end
                8'h31: begin letter = 1'b1; li = 5'd13; end
                8'h44: begin letter = 1'b1; li = 5'd14; end
                8'h4D: begin letter = 1'b1; li = 5'd15; end
                8'h15: begin letter = 1'b1; li = 5'd16; end
                8'h2D: begin letter = 1'b1; li = 5'd17; end
                8'h1B: begin letter = 1'b1; li = 5'd18; end
                8'h2C: begin letter = 1'b1; li = 5'd19; end
                8'h3C: begin letter = 1'b1; li = 5'd20; end
                8'h2A: begin letter = 1'b1; li = 5'd21; end
                8'h1D: begin letter = 1'b1; li = 5'd22; end
                8'h22: begin letter = 1'b1; li = 5'd23; end
                8'h35: begin letter = 1'b1; li = 5'd24; end
                8'h1A: begin letter = 1'b1; li = 5'd25; end
                8'h45: r = 8'd48;
                8'h16: r = 8'd49;
                8'h1E: r = 8'd50;
                8'h26: r = 8'd51;
                8'h25: r = 8'd52;
                8'h2E: r = 8'd53;
                8'h36: r = 8'd54;
                8'h3D: r = 8'd55;
                8'h3E: r = 8'd56;
                8'h46: r = 8'd57;
                8'h29: r = 8'd32;
                8'h5A: r = 8'd128;
                8'h66: r = 8'd129;
                8'h76: r = 8'd140;
                8'h05: r = 8'd141;
                8'h06: r = 8'd142;
                8'h04: r = 8'd143;
                8'h0C: r = 8'd144;
                8'h03: r = 8'd145;
                8'h0B: r = 8'd146;
                8'h83: r = 8'd147;
                8'h0A: r = 8'd148;
                8'h01: r = 8'd149;
                8'h09: r = 8'd150;
                8'h78: r = 8'd151;
                8'h07: r = 8'd152;
                default: r = 8'd0;
            endcase
            if (letter)
                r = (sh ? 8'd97 : 8'd65) + {3'b000, li};
        end
        return r;
    endfunction

    // Stage p0: edge detect on the synchronised bus and translation of the assembled byte
    always_comb begin
        fall_p0 = clk_prev & ~clk_sync[SYNC_STAGES-1];
        bit_p0  = data_sync[SYNC_STAGES-1];
        code_p0 = xlate(ext, shreg, shift);
    end

    assign key = {8'h00, key_lo};

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync   <= '1;
            data_sync  <= '1;
            clk_prev   <= 1'b1;
            state      <= IDLE;
            bit_cnt    <= 3'd0;
            shreg      <= 8'h00;
            par        <= 1'b0;
            tcnt       <= '0;
            ext        <= 1'b0;
            brk        <= 1'b0;
            shift      <= 1'b0;
            key_lo     <= 8'h00;
            scan_valid <= 1'b0;
            scan_code  <= 8'h00;
            frame_err  <= 1'b0;
        end else begin
            clk_sync   <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync  <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev   <= clk_sync[SYNC_STAGES-1];
            scan_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (fall_p0) begin
                tcnt <= '0;
                case (state)
                    IDLE: begin
                        if (!bit_p0) begin
                            state   <= DATA;
                            bit_cnt <= 3'd0;
                        end
                    end
                    DATA: begin
                        shreg   <= {bit_p0, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7)
                            state <= PARITY;
                    end
                    PARITY: begin
                        par   <= bit_p0;
                        state <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (bit_p0 && (^{shreg, par})) begin
                            scan_valid <= 1'b1;
                            scan_code  <= shreg;
                            if (shreg == 8'hE0) begin
                                ext <= 1'b1;
                            end else if (shreg == 8'hF0) begin
                                brk <= 1'b1;
                            end else begin
                                ext <= 1'b0;
                                brk <= 1'b0;
                                if (!ext && (shreg == 8'h12 || shreg == 8'h59))
                                    shift <= ~brk;
                                else if (!brk && code_p0 != 8'h00)
                                    key_lo <= code_p0;
                                else if (brk && code_p0 != 8'h00 && code_p0 == key_lo)
                                    key_lo <= 8'h00;
                            end
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE) begin
                // A stalled keyboard must not wedge the receiver mid-frame.
                if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    state     <= IDLE;
                    frame_err <= 1'b1;
                    tcnt      <= '0;
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
            end else begin
                tcnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_ps2_keyboard.sv
// Directed bench for ps2_keyboard: bit-banged PS/2 frames with hand-computed key codes.
module tb_ps2_keyboard;
    localparam int TO = 200;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [15:0] key;
    logic        scan_valid;
    logic [7:0]  scan_code;
    logic        frame_err;

    int          n_chk = 0;
    int          n_fail = 0;
    int          sv_cnt = 0;
    int          err_cnt = 0;
    int          s0, e0;
    logic [7:0]  last_sc = 8'h00;
    logic [15:0] key_at_sv = 16'h0000;

    ps2_keyboard #(.TIMEOUT_CYCLES(TO), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .key(key), .scan_valid(scan_valid), .scan_code(scan_code), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (scan_valid) begin
            sv_cnt++;
            last_sc   = scan_code;
            key_at_sv = key;
        end
        if (frame_err) err_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        repeat (4) @(posedge clk);
        ps2_clk = 1'b0;
        repeat (8) @(posedge clk);
        ps2_clk = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(~(^b) ^ bad_par);
        send_bit(stop);
        ps2_data = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_key", key, 0);
        chk("rst_scan_code", scan_code, 0);
        chk("rst_scan_valid", scan_valid, 0);
        chk("rst_frame_err", frame_err, 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        s0 = sv_cnt; e0 = err_cnt;
        send(8'h1C);
        chk("a_sv", sv_cnt - s0, 1);
        chk("a_code", last_sc, 8'h1C);
        chk("a_key_same_cycle", key_at_sv, 65);
        chk("a_no_err", err_cnt - e0, 0);
        chk("a_key", key, 65);

        send(8'hF0); send(8'h1C);
        chk("a_break_sv", sv_cnt - s0, 3);
        chk("a_break_key", key, 0);

        send(8'h12); send(8'h1C);
        chk("shift_a", key, 97);
        send(8'hF0); send(8'h1C);
        chk("shift_a_break", key, 0);
        send(8'hF0); send(8'h12); send(8'h1C);
        chk("shift_cleared", key, 65);

        send(8'hE0); send(8'h6B);
        chk("left", key, 130);
        send(8'h1C);
        chk("a_after_left", key, 65);
        send(8'hE0); send(8'hF0); send(8'h6B);
        chk("left_break_other", key, 65);

        s0 = sv_cnt; e0 = err_cnt;
        send_frame(8'h16, 1'b1, 1'b1);
        chk("par_err", err_cnt - e0, 1);
        chk("par_no_sv", sv_cnt - s0, 0);
        chk("par_key", key, 65);
        send_frame(8'h16, 1'b0, 1'b0);
        chk("stop_err", err_cnt - e0, 2);
        chk("stop_no_sv", sv_cnt - s0, 0);
        chk("stop_key", key, 65);

        s0 = sv_cnt; e0 = err_cnt;
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        ps2_data = 1'b1;
        repeat (TO + 50) @(posedge clk);
        @(negedge clk);
        chk("timeout_err", err_cnt - e0, 1);
        chk("timeout_no_sv", sv_cnt - s0, 0);
        send(8'h16);
        chk("after_timeout_1", key, 49);
        send(8'hF0); send(8'h1C);
        chk("break_other_key", key, 49);

        send(8'h12); send(8'h45);
        chk("shift_digit0", key, 48);
        send(8'hF0); send(8'h12);
        send(8'h05);
        chk("f1", key, 141);
        send(8'h5A);
        chk("enter", key, 128);
        send(8'h0E);
        chk("unmapped_keep", key, 128);
        send(8'hE0); send(8'h75);
        chk("up", key, 131);
        send(8'h2D);
        chk("r_upper", key, 82);

        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        ps2_data = 1'b1;
        s0 = sv_cnt; e0 = err_cnt;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        repeat (TO + 50) @(negedge clk);
        chk("midrst_key", key, 0);
        chk("midrst_no_sv", sv_cnt - s0, 0);
        chk("midrst_no_err", err_cnt - e0, 0);
        send(8'h1A);
        chk("after_rst_z", key, 90);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
